ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  decoded instruction and operands are present.
REQ-005 in_ready  out  1  stage accepts an instruction this cycle.
REQ-006 opcode  in  7, func3  in  3, func7  in  7  decoded instruction fields.
REQ-007 rs1_data, rs2_data  in  XLEN  register-file read data.
REQ-008 ext_imm  in  XLEN  sign-extended immediate.
REQ-009 pc  in  XLEN  address of the instruction being issued.
REQ-010 flush  in  1  discard any in-flight or held result.
REQ-011 out_valid  out  1  result is valid; out_ready  in  1  consumer takes the result.
REQ-012 result  out  XLEN  rd write value; rd_we  out  1  instruction writes rd.
REQ-013 br_taken  out  1  redirect required; br_target  out  XLEN  redirect address.
REQ-014 busy  out  1  divider iteration in progress.

Function
REQ-015 Accept occurs on any rising edge with in_valid=1 and in_ready=1.
REQ-016 in_ready = (state==IDLE) and (out_valid==0 or out_ready==1), with no combinational dependence on in_valid.
REQ-017 Supported classes: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, and M-extension (opcode 0110011, func7 0000001); any other opcode completes with rd_we=0 and br_taken=0.
REQ-018 The second operand is ext_imm for OP-IMM, LUI, AUIPC, JAL and JALR, and rs2_data otherwise; shift amount = operand[4:0].
REQ-019 LUI result = ext_imm; AUIPC result = pc+ext_imm; JAL/JALR result = pc+4.
REQ-020 JAL br_target = pc+ext_imm; JALR br_target = (rs1_data+ext_imm) with bit0 cleared; br_taken=1 for both.
REQ-021 BRANCH: br_target = pc+ext_imm; br_taken follows func3 (BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned); rd_we=0.
REQ-022 Single-cycle classes and MUL/MULH/MULHSU/MULHU: outputs are registered on the accept edge, giving out_valid=1 in the next cycle (latency 1).
REQ-023 MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-024 DIV/DIVU/REM/REMU use a radix-2 restoring divider on magnitudes, with state machine IDLE -> DIV -> DONE -> IDLE.
REQ-025 Divider timing: accept -> DIV; a 5-bit counter runs 31..0, one quotient bit per cycle; counter==0 -> DONE; the sign-corrected result registers with out_valid=1 on the DONE-exit edge, 33 edges after accept.
REQ-026 Divider signs: quotient is negated if operand signs differ (signed ops); remainder takes the dividend's sign.
REQ-027 Divide by zero completes in 1 cycle: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1_data.
REQ-028 Signed overflow (0x80000000 / 0xFFFFFFFF) completes in 1 cycle: DIV returns 0x80000000; REM returns 0.
REQ-029 busy=1 exactly while state==DIV or state==DONE.
REQ-030 While out_valid=1 and out_ready=0, result, rd_we, br_taken and br_target shall hold stable.
REQ-031 out_valid clears on an edge with out_ready=1 unless a new accept occurs on the same edge (back-to-back: one result per cycle).
REQ-032 flush=1 forces state=IDLE and out_valid=0 on that edge, blocks accept on that edge, and discards divider progress.
REQ-033 rst and flush asserted together behave as rst.

Reset
REQ-034 On rst: state=IDLE, counter=0, out_valid=0, result=0, rd_we=0, br_taken=0, br_target=0, and busy=0.
REQ-035 Reset asserted mid-divide abandons the operation with no out_valid pulse; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-036 ADDI with rs1=5 and imm=-7 -> one cycle later out_valid=1, result=0xFFFFFFFE, rd_we=1.
REQ-037 BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100 and imm=0x20 -> br_taken=1, br_target=0x120, rd_we=0; the same operands with BLTU -> br_taken=0.
REQ-038 DIV with -7/2 -> busy for 32+1 cycles, in_ready=0 throughout, then result=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-039 DIVU x/0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/-1 -> 0x80000000 after 1 cycle; REMU 9/0 -> 9.
REQ-040 Hold out_ready=0 for 3 cycles after MULHU 0xFFFFFFFF*0xFFFFFFFF -> result stays 0xFFFFFFFE and in_ready=0; release -> next instruction accepted on that same edge.
REQ-041 flush at iteration 10 of a DIV -> out_valid never rises for that DIV, busy=0 and in_ready=1 the next cycle.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage with a valid/ready handshake on both sides.
//
// Single-cycle ALU, branch, jump and multiply operations register their
// outputs on the accept edge. DIV/DIVU/REM/REMU run a 32-iteration radix-2
// restoring divider on operand magnitudes and apply the signs at the end.
// Divide-by-zero and signed overflow bypass the divider and finish in one cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       instruction handshake (in_ready ignores in_valid)
//   opcode, func3, func7      decoded instruction fields
//   rs1_data, rs2_data        register operands
//   ext_imm, pc               sign-extended immediate, instruction address
//   flush                     drop any in-flight or held result
//   out_valid / out_ready     result handshake
//   result, rd_we             rd write value and write enable
//   br_taken, br_target       redirect request and address
//   busy                      divider is iterating or finishing
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] ext_imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            rd_we,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            busy
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t            state_reg, state_next;
    logic [4:0]        counter_reg;
    logic              out_valid_reg;
    logic [XLEN-1:0]   result_reg, br_target_reg;
    logic              rd_we_reg, br_taken_reg;
    logic [XLEN-1:0]   quo_reg, rem_reg, dvs_reg;
    logic              neg_q_reg, neg_r_reg, sel_rem_reg;

    // Decode
    logic            is_op, is_m, use_imm, accept, div_zero, div_ovf, div_long;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;

    assign is_op    = (opcode == OPC_OP);
    assign is_m     = is_op && (func7 == F7_MEXT);
    assign use_imm  = (opcode == OPC_OP_IMM) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                      (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign op_b     = use_imm ? ext_imm : rs2_data;
    assign shamt    = op_b[4:0];
    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // func3[0]=0 selects the signed divide variants (DIV, REM)
    assign div_zero = (rs2_data == '0);
    assign div_ovf  = !func3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign div_long = is_m && func3[2] && !div_zero && !div_ovf;

    // Multiplier: 33-bit operands so one signed multiply covers all variants
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod;
    assign mul_a = {(func3[1:0] != 2'b11) & rs1_data[XLEN-1], rs1_data};
    assign mul_b = {!func3[1] & rs2_data[XLEN-1], rs2_data};
    assign prod  = mul_a * mul_b;

    // Divider operand magnitudes and result signs
    logic a_neg, b_neg;
    assign a_neg = !func3[0] && rs1_data[XLEN-1];
    assign b_neg = !func3[0] && rs2_data[XLEN-1];

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [XLEN:0] rem_shift, diff;
    assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_reg};

    logic [XLEN-1:0] quo_final, rem_final;
    assign quo_final = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_final = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

    // Single-cycle datapath
    logic [XLEN-1:0] alu_out, sc_result, sc_target;
    logic            sc_we, sc_taken, br_cond;

    always_comb begin
        alu_out = '0;
        case (func3)
            3'b000: alu_out = (is_op && func7[5]) ? rs1_data - op_b : rs1_data + op_b;
            3'b001: alu_out = rs1_data << shamt;
            3'b010: alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
            3'b011: alu_out = {{(XLEN-1){1'b0}}, rs1_data < op_b};
            3'b100: alu_out = rs1_data ^ op_b;
            3'b101: alu_out = func7[5] ? XLEN'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
            3'b110: alu_out = rs1_data | op_b;
            default: alu_out = rs1_data & op_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (func3)
            3'b000: br_cond = (rs1_data == rs2_data);
            3'b001: br_cond = (rs1_data != rs2_data);
            3'b100: br_cond = $signed(rs1_data) < $signed(rs2_data);
            3'b101: br_cond = $signed(rs1_data) >= $signed(rs2_data);
            3'b110: br_cond = rs1_data < rs2_data;
            3'b111: br_cond = rs1_data >= rs2_data;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        sc_result = '0;
        sc_we     = 1'b0;
        sc_taken  = 1'b0;
        sc_target = '0;
        case (opcode)
            OPC_LUI: begin
                sc_result = ext_imm;
                sc_we     = 1'b1;
            end
            OPC_AUIPC: begin
                sc_result = pc + ext_imm;
                sc_we     = 1'b1;
            end
            OPC_JAL: begin
                sc_result = pc + 32'd4;
                sc_we     = 1'b1;
                sc_taken  = 1'b1;
                sc_target = pc + ext_imm;
            end
            OPC_JALR: begin
                sc_result = pc + 32'd4;
                sc_we     = 1'b1;
                sc_taken  = 1'b1;
                sc_target = (rs1_data + ext_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            OPC_BRANCH: begin
                sc_taken  = br_cond;
                sc_target = pc + ext_imm;
            end
            OPC_OP_IMM: begin
                sc_result = alu_out;
                sc_we     = 1'b1;
            end
            OPC_OP: begin
                sc_we = 1'b1;
                if (!is_m)
                    sc_result = alu_out;
                else if (!func3[2])
                    sc_result = (func3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                else if (div_zero)
                    sc_result = func3[1] ? rs1_data : '1;
                else
                    sc_result = func3[1] ? '0 : rs1_data;   // signed overflow
            end
            default: ;
        endcase
    end

    logic unused_prod_bits;
    assign unused_prod_bits = ^prod[2*XLEN+1:2*XLEN];

    // FSM next state
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (accept && div_long) state_next = DIV;
                DIV:  if (counter_reg == 5'd0) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            counter_reg   <= 5'd0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            rd_we_reg     <= 1'b0;
            br_taken_reg  <= 1'b0;
            br_target_reg <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            dvs_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            sel_rem_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
                counter_reg   <= 5'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept && div_long) begin
                            counter_reg   <= 5'd31;
                            quo_reg       <= a_neg ? (~rs1_data + 1'b1) : rs1_data;
                            dvs_reg       <= b_neg ? (~rs2_data + 1'b1) : rs2_data;
                            rem_reg       <= '0;
                            neg_q_reg     <= a_neg ^ b_neg;
                            neg_r_reg     <= a_neg;
                            sel_rem_reg   <= func3[1];
                            out_valid_reg <= 1'b0;
                        end else if (accept) begin
                            result_reg    <= sc_result;
                            rd_we_reg     <= sc_we;
                            br_taken_reg  <= sc_taken;
                            br_target_reg <= sc_target;
                            out_valid_reg <= 1'b1;
                        end else if (out_ready) begin
                            out_valid_reg <= 1'b0;
                        end
                    end
                    DIV: begin
                        if (counter_reg != 5'd0)
                            counter_reg <= counter_reg - 5'd1;
                        if (!diff[XLEN]) begin
                            rem_reg <= diff[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_shift[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                        end
                    end
                    DONE: begin
                        result_reg    <= sel_rem_reg ? rem_final : quo_final;
                        rd_we_reg     <= 1'b1;
                        br_taken_reg  <= 1'b0;
                        br_target_reg <= '0;
                        out_valid_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign rd_we     = rd_we_reg;
    assign br_taken  = br_taken_reg;
    assign br_target = br_target_reg;
    assign busy      = (state_reg == DIV) || (state_reg == DONE);
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Expected results are pushed
// when an instruction is accepted and compared when out_valid/out_ready
// complete a transfer; timing and handshake behaviour is checked inline.
module tb_ex_stage;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                           BR = 7'b1100011, MX = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic        rd_we, br_taken, busy;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1_data, rs2_data, ext_imm, pc, result, br_target;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ext_imm(ext_imm), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_we(rd_we), .br_taken(br_taken), .br_target(br_target),
        .busy(busy)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        we;
        logic        tk;
        logic [31:0] tgt;
        logic        cres;
        logic        ctgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Scoreboard monitor: a transfer happens on the edge after this sample
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got res=%h we=%b tk=%b, required no output", result, rd_we, br_taken);
            end else begin
                mon_e = sb.pop_front();
                if (rd_we !== mon_e.we || br_taken !== mon_e.tk ||
                    (mon_e.cres && result !== mon_e.res) || (mon_e.ctgt && br_target !== mon_e.tgt)) begin
                    n_err++;
                    $display("FAIL %s got res=%h we=%b tk=%b tgt=%h required res=%h we=%b tk=%b tgt=%h",
                             mon_e.name, result, rd_we, br_taken, br_target,
                             mon_e.res, mon_e.we, mon_e.tk, mon_e.tgt);
                end else begin
                    $display("ok   %s res=%h we=%b tk=%b tgt=%h", mon_e.name, result, rd_we, br_taken, br_target);
                end
            end
        end
    end

    // Drive one instruction and wait (bounded) for it to be accepted.
    task automatic send(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic [31:0] p,
                        input logic [31:0] eres, input logic ewe, input logic etk, input logic [31:0] etgt,
                        input logic cres, input logic ctgt, output int waits);
        exp_t e;
        bit   acc;
        opcode = op; func3 = f3; func7 = f7;
        rs1_data = a; rs2_data = b; ext_imm = imm; pc = p;
        in_valid = 1'b1;
        e.name = nm; e.res = eres; e.we = ewe; e.tk = etk; e.tgt = etgt; e.cres = cres; e.ctgt = ctgt;
        acc = 1'b0;
        waits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_accept_timeout got in_ready=%b, required accept within 100 cycles", nm, in_ready);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0; rs1_data = '0; rs2_data = '0; ext_imm = '0; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, rd_we, br_taken, busy} !== 4'b0000 || result !== 32'h0 || br_target !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state got v=%b we=%b tk=%b busy=%b res=%h tgt=%h, required all zero",
                     out_valid, rd_we, br_taken, busy, result, br_target);
        end
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    // Single-cycle classes issued back to back; each must be taken immediately.
    task automatic test_back_to_back();
        int w;
        int total;
        total = 0;
        send("addi",   OPI, 3'b000, 7'h00, 32'd5, 32'd0, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFE, 1, 0, 0, 1, 0, w); total += w;
        send("blt",    BR,  3'b100, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 0, 1, 32'h120, 0, 1, w); total += w;
        send("bltu",   BR,  3'b110, 7'h00, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 0, 0, 32'h120, 0, 1, w); total += w;
        send("sub",    OP,  3'b000, 7'h20, 32'd3, 32'd5, 32'h0, 32'h0, 32'hFFFFFFFE, 1, 0, 0, 1, 0, w); total += w;
        send("sra",    OP,  3'b101, 7'h20, 32'h80000000, 32'd4, 32'h0, 32'h0, 32'hF8000000, 1, 0, 0, 1, 0, w); total += w;
        send("srai",   OPI, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h404, 32'h0, 32'hF8000000, 1, 0, 0, 1, 0, w); total += w;
        send("slt",    OP,  3'b010, 7'h00, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd0, 1, 0, 0, 1, 0, w); total += w;
        send("sltu",   OP,  3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd1, 1, 0, 0, 1, 0, w); total += w;
        send("lui",    LUI, 3'b000, 7'h00, 32'h0, 32'h0, 32'h12345000, 32'h0, 32'h12345000, 1, 0, 0, 1, 0, w); total += w;
        send("auipc",  AUIPC, 3'b000, 7'h00, 32'h0, 32'h0, 32'h2000, 32'h1000, 32'h3000, 1, 0, 0, 1, 0, w); total += w;
        send("jal",    JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'h40, 32'h200, 32'h204, 1, 1, 32'h240, 1, 1, w); total += w;
        send("jalr",   JALR, 3'b000, 7'h00, 32'h301, 32'h0, 32'h10, 32'h400, 32'h404, 1, 1, 32'h310, 1, 1, w); total += w;
        send("mul",    OP,  3'b000, MX, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFEB, 1, 0, 0, 1, 0, w); total += w;
        send("mulh",   OP,  3'b001, MX, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 1, 0, 0, 1, 0, w); total += w;
        send("mulhsu", OP,  3'b010, MX, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1, 0, w); total += w;
        send("illegal", 7'b0000000, 3'b000, 7'h00, 32'd1, 32'd2, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, w); total += w;
        idle(3);
        n_vec++;
        if (total !== 0) begin
            n_err++;
            $display("FAIL back_to_back_stalls got %0d stall cycles required 0", total);
        end
    endtask

    task automatic test_div_special();
        int w;
        send("divu_by0", OP, 3'b101, MX, 32'h1234, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1, 0, w);
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL divu_by0_latency got v=%b busy=%b required v=1 busy=0", out_valid, busy);
        end
        send("div_ovf", OP, 3'b100, MX, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000, 1, 0, 0, 1, 0, w);
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL div_ovf_latency got v=%b busy=%b required v=1 busy=0", out_valid, busy);
        end
        send("remu_by0", OP, 3'b111, MX, 32'd9, 32'h0, 32'h0, 32'h0, 32'd9, 1, 0, 0, 1, 0, w);
        send("rem_ovf",  OP, 3'b110, MX, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1, 0, w);
        idle(3);
    endtask

    task automatic test_div_timing();
        int w;
        int bad_busy, bad_rdy, bad_v;
        bad_busy = 0; bad_rdy = 0; bad_v = 0;
        send("div_m7_2", OP, 3'b100, MX, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFD, 1, 0, 0, 1, 0, w);
        // Next instruction waits with in_valid high the whole time.
        opcode = OP; func3 = 3'b110; func7 = MX; rs1_data = 32'hFFFFFFF9; rs2_data = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (in_ready !== 1'b0) bad_rdy++;
            if (out_valid !== 1'b0) bad_v++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (bad_busy != 0) begin
            n_err++;
            $display("FAIL div_busy got %0d cycles without busy, required 0 of 33", bad_busy);
        end
        n_vec++;
        if (bad_rdy != 0) begin
            n_err++;
            $display("FAIL div_in_ready got %0d cycles with in_ready, required 0 of 33", bad_rdy);
        end
        n_vec++;
        if (bad_v != 0) begin
            n_err++;
            $display("FAIL div_early_valid got %0d early out_valid cycles, required 0", bad_v);
        end
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL div_done_edge got v=%b busy=%b required v=1 busy=0", out_valid, busy);
        end
        send("rem_m7_2", OP, 3'b110, MX, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1, 0, w);
        n_vec++;
        if (w !== 0) begin
            n_err++;
            $display("FAIL rem_after_div_accept got %0d waits required 0", w);
        end
        send("divu_100_7", OP, 3'b101, MX, 32'd100, 32'd7, 32'h0, 32'h0, 32'd14, 1, 0, 0, 1, 0, w);
        send("remu_100_7", OP, 3'b111, MX, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 1, 0, 0, 1, 0, w);
        send("div_7_m2",   OP, 3'b100, MX, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFD, 1, 0, 0, 1, 0, w);
        send("rem_7_m2",   OP, 3'b110, MX, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 1, 0, 0, 1, 0, w);
        idle(36);
    endtask

    task automatic test_hold();
        int w;
        out_ready = 1'b0;
        send("mulhu", OP, 3'b011, MX, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 1, 0, 0, 1, 0, w);
        opcode = OPI; func3 = 3'b000; func7 = 7'h00; rs1_data = 32'd5; ext_imm = 32'hFFFFFFF9;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || result !== 32'hFFFFFFFE || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d got v=%b res=%h rdy=%b required v=1 res=fffffffe rdy=0",
                         i, out_valid, result, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send("addi_after_hold", OPI, 3'b000, 7'h00, 32'd5, 32'd0, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFE, 1, 0, 0, 1, 0, w);
        n_vec++;
        if (w !== 0) begin
            n_err++;
            $display("FAIL hold_release_accept got %0d waits required 0", w);
        end
        idle(3);
    endtask

    task automatic test_flush();
        int w;
        int bad_v;
        bad_v = 0;
        send("div_flushed", OP, 3'b101, MX, 32'd100, 32'd7, 32'h0, 32'h0, 32'd14, 1, 0, 0, 1, 0, w);
        idle(10);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_state got busy=%b rdy=%b v=%b required busy=0 rdy=1 v=0", busy, in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad_v++;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (bad_v != 0) begin
            n_err++;
            $display("FAIL flush_no_valid got %0d out_valid cycles required 0", bad_v);
        end
    endtask

    task automatic test_reset_mid_div();
        int w;
        send("div_reset", OP, 3'b100, MX, 32'd50, 32'd3, 32'h0, 32'h0, 32'd16, 1, 0, 0, 1, 0, w);
        idle(5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, rd_we, br_taken, busy} !== 4'b0000 || result !== 32'h0 || br_target !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_div got v=%b we=%b tk=%b busy=%b res=%h tgt=%h required all zero",
                     out_valid, rd_we, br_taken, busy, result, br_target);
        end
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_in_ready got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        send("addi_after_rst", OPI, 3'b000, 7'h00, 32'd10, 32'd0, 32'd20, 32'h0, 32'd30, 1, 0, 0, 1, 0, w);
        idle(5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_div_special();
        test_div_timing();
        test_hold();
        test_flush();
        test_reset_mid_div();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
